// File: rtl/alu_sequencer.sv
// alu_sequencer
// Issuing side of a 16-bit ALU interface. It accepts one register-format
// instruction at a time over a valid/ready handshake. It reads both operands
// from an internal register file and presents them, with carry and opcode,
// to an external combinational ALU. It then captures the ALU result and the
// zero/negative flags, and writes the result back to the register file.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   instrValid/instrReady         instruction handshake
//   instrOp/Dst/SrcA/SrcB/C       instruction fields (op 3'b111 = NOP)
//   ldEn/ldAddr/ldData            register load port (honoured in IDLE only)
//   rdAddr/rdData                 combinational observation read port
//   aluA/aluB/aluC/aluOp          registered operands to the ALU
//   aluW/aluZero/aluNeg           ALU result and flags
//   flagZ/flagN                   sticky flags of last executed non-NOP
//   done                          one-cycle pulse while in WB
//
// state | meaning
// IDLE  | waiting; loads or accepts an instruction
// READ  | register file read into the ALU operand registers
// EXEC  | ALU settles; result and flags captured at end of cycle
// WB    | done pulses; result and flags committed at end of cycle
module alu_sequencer #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instrValid,
   output logic             instrReady,
   input  logic [2:0]       instrOp,
   input  logic [AW-1:0]    instrDst,
   input  logic [AW-1:0]    instrSrcA,
   input  logic [AW-1:0]    instrSrcB,
   input  logic             instrC,
   input  logic             ldEn,
   input  logic [AW-1:0]    ldAddr,
   input  logic [WIDTH-1:0] ldData,
   input  logic [AW-1:0]    rdAddr,
   output logic [WIDTH-1:0] rdData,
   output logic [WIDTH-1:0] aluA,
   output logic [WIDTH-1:0] aluB,
   output logic             aluC,
   output logic [2:0]       aluOp,
   input  logic [WIDTH-1:0] aluW,
   input  logic             aluZero,
   input  logic             aluNeg,
   output logic             flagZ,
   output logic             flagN,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   localparam logic [2:0] OP_NOP = 3'b111;

   state_t           state;
   logic [WIDTH-1:0] regs [NREG];
   logic [2:0]       op_q;
   logic [AW-1:0]    dst_q;
   logic [AW-1:0]    srca_q;
   logic [AW-1:0]    srcb_q;
   logic             c_q;
   logic [WIDTH-1:0] res_q;
   logic             resz_q;
   logic             resn_q;

   // A load in IDLE takes priority over accepting an instruction.
   assign instrReady = (state == IDLE) && !ldEn;
   assign rdData     = regs[rdAddr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         aluA   <= '0;
         aluB   <= '0;
         aluC   <= 1'b0;
         aluOp  <= '0;
         flagZ  <= 1'b0;
         flagN  <= 1'b0;
         done   <= 1'b0;
         op_q   <= '0;
         dst_q  <= '0;
         srca_q <= '0;
         srcb_q <= '0;
         c_q    <= 1'b0;
         res_q  <= '0;
         resz_q <= 1'b0;
         resn_q <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (ldEn) begin
                  regs[ldAddr] <= ldData;
               end else if (instrValid) begin
                  op_q   <= instrOp;
                  dst_q  <= instrDst;
                  srca_q <= instrSrcA;
                  srcb_q <= instrSrcB;
                  c_q    <= instrC;
                  state  <= READ;
               end
            end
            READ: begin
               aluA  <= regs[srca_q];
               aluB  <= regs[srcb_q];
               aluC  <= c_q;
               aluOp <= op_q;
               state <= EXEC;
            end
            EXEC: begin
               res_q  <= aluW;
               resz_q <= aluZero;
               resn_q <= aluNeg;
               done   <= 1'b1;
               state  <= WB;
            end
            WB: begin
               if (op_q != OP_NOP) begin
                  regs[dst_q] <= res_q;
                  flagZ       <= resz_q;
                  flagN       <= resn_q;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instrValid = 1'b0;
   logic        instrReady;
   logic [2:0]  instrOp = 3'd0;
   logic [2:0]  instrDst = 3'd0;
   logic [2:0]  instrSrcA = 3'd0;
   logic [2:0]  instrSrcB = 3'd0;
   logic        instrC = 1'b0;
   logic        ldEn = 1'b0;
   logic [2:0]  ldAddr = 3'd0;
   logic [15:0] ldData = 16'd0;
   logic [2:0]  rdAddr = 3'd0;
   logic [15:0] rdData;
   logic [15:0] aluA, aluB;
   logic        aluC;
   logic [2:0]  aluOp;
   logic [15:0] aluW;
   logic        aluZero, aluNeg;
   logic        flagZ, flagN, done;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(16), .NREG(8), .AW(3)) dut (
      .clk(clk), .rst(rst),
      .instrValid(instrValid), .instrReady(instrReady),
      .instrOp(instrOp), .instrDst(instrDst),
      .instrSrcA(instrSrcA), .instrSrcB(instrSrcB), .instrC(instrC),
      .ldEn(ldEn), .ldAddr(ldAddr), .ldData(ldData),
      .rdAddr(rdAddr), .rdData(rdData),
      .aluA(aluA), .aluB(aluB), .aluC(aluC), .aluOp(aluOp),
      .aluW(aluW), .aluZero(aluZero), .aluNeg(aluNeg),
      .flagZ(flagZ), .flagN(flagN), .done(done)
   );

   // External ALU: 000 negate A, 001 A-B, 010 A+B+C, 011 OR, 100 AND,
   // 101 XOR, 110 {A lo byte, B lo byte}.
   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
      case (op)
         3'd0:    return 16'd0 - a;
         3'd1:    return a - b;
         3'd2:    return a + b + {15'd0, c};
         3'd3:    return a | b;
         3'd4:    return a & b;
         3'd5:    return a ^ b;
         3'd6:    return {a[7:0], b[7:0]};
         default: return a;
      endcase
   endfunction

   assign aluW    = alu_f(aluOp, aluA, aluB, aluC);
   assign aluZero = (aluW == 16'd0);
   assign aluNeg  = aluW[15];

   // Reference model: an instruction is a transaction captured at acceptance
   // (operands read then) that commits its result three edges later.
   logic [15:0] m_regs [8];
   logic        m_z, m_n;
   logic        pend;
   int          age;
   logic [15:0] cap_a, cap_b;
   logic        cap_c;
   logic [2:0]  cap_op, cap_dst;
   logic [15:0] e_a, e_b;
   logic        e_c;
   logic [2:0]  e_op;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) m_regs[i] <= 16'd0;
         m_z <= 1'b0; m_n <= 1'b0; pend <= 1'b0; age <= 0;
         e_a <= 16'd0; e_b <= 16'd0; e_c <= 1'b0; e_op <= 3'd0;
      end else if (!pend) begin
         if (ldEn) begin
            m_regs[ldAddr] <= ldData;
         end else if (instrValid) begin
            pend    <= 1'b1;
            age     <= 0;
            cap_a   <= m_regs[instrSrcA];
            cap_b   <= m_regs[instrSrcB];
            cap_c   <= instrC;
            cap_op  <= instrOp;
            cap_dst <= instrDst;
         end
      end else begin
         age <= age + 1;
         if (age == 0) begin
            e_a <= cap_a; e_b <= cap_b; e_c <= cap_c; e_op <= cap_op;
         end
         if (age == 2) begin
            pend <= 1'b0;
            if (cap_op != 3'b111) begin
               m_regs[cap_dst] <= alu_f(cap_op, cap_a, cap_b, cap_c);
               m_z <= (alu_f(cap_op, cap_a, cap_b, cap_c) == 16'd0);
               m_n <= alu_f(cap_op, cap_a, cap_b, cap_c) >> 15;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("instrReady", {31'd0, instrReady}, {31'd0, !pend && !ldEn});
         chk("done", {31'd0, done}, {31'd0, pend && age == 2});
         chk("rdData", {16'd0, rdData}, {16'd0, m_regs[rdAddr]});
         chk("flagZ", {31'd0, flagZ}, {31'd0, m_z});
         chk("flagN", {31'd0, flagN}, {31'd0, m_n});
         chk("aluA", {16'd0, aluA}, {16'd0, e_a});
         chk("aluB", {16'd0, aluB}, {16'd0, e_b});
         chk("aluC", {31'd0, aluC}, {31'd0, e_c});
         chk("aluOp", {29'd0, aluOp}, {29'd0, e_op});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] a, input logic [15:0] d);
      ldEn = 1'b1; ldAddr = a; ldData = d;
      tick();
      ldEn = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
      rdAddr = a;
      #1;
      chk(name, {16'd0, rdData}, {16'd0, exp});
   endtask

   // Issue one instruction, check done latency, and step past writeback.
   task automatic issue(input logic [2:0] op, input logic [2:0] dst,
                        input logic [2:0] sa, input logic [2:0] sb, input logic c);
      int n;
      instrValid = 1'b1; instrOp = op; instrDst = dst;
      instrSrcA = sa; instrSrcB = sb; instrC = c;
      tick();
      instrValid = 1'b0;
      n = 0;
      while (!done && n < 8) begin
         tick();
         n++;
      end
      chk("done_latency", n, 2);
      tick();
   endtask

   initial begin
      repeat (2) tick();
      chk_en = 1;
      // Reset state pins.
      chk("rst_aluA", {16'd0, aluA}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_flagZ", {31'd0, flagZ}, 32'd0);
      rd_chk("rst_R5", 3'd5, 16'd0);
      rst = 1'b0;
      tick();
      chk("ready_idle", {31'd0, instrReady}, 32'd1);

      // 1: 5 + 7 + 1
      load(3'd1, 16'd5);
      load(3'd2, 16'd7);
      issue(3'b010, 3'd3, 3'd1, 3'd2, 1'b1);
      rd_chk("t1_R3", 3'd3, 16'd13);
      chk("t1_flagZ", {31'd0, flagZ}, 32'd0);
      chk("t1_flagN", {31'd0, flagN}, 32'd0);

      // 2: negate R1
      issue(3'b000, 3'd4, 3'd1, 3'd1, 1'b0);
      rd_chk("t2_R4", 3'd4, 16'hFFFB);
      chk("t2_flagN", {31'd0, flagN}, 32'd1);
      chk("t2_flagZ", {31'd0, flagZ}, 32'd0);

      // 3: byte merge, then AND with zero
      load(3'd5, 16'h12AB);
      load(3'd6, 16'h34CD);
      issue(3'b110, 3'd7, 3'd5, 3'd6, 1'b0);
      rd_chk("t3_R7", 3'd7, 16'hABCD);
      issue(3'b100, 3'd4, 3'd7, 3'd0, 1'b0);
      rd_chk("t3_R4", 3'd4, 16'h0000);
      chk("t3_flagZ", {31'd0, flagZ}, 32'd1);
      chk("t3_flagN", {31'd0, flagN}, 32'd0);

      // 4: NOP leaves everything alone
      issue(3'b111, 3'd7, 3'd1, 3'd2, 1'b1);
      rd_chk("t4_R7", 3'd7, 16'hABCD);
      rd_chk("t4_R3", 3'd3, 16'd13);
      chk("t4_flagZ", {31'd0, flagZ}, 32'd1);

      // 5: reset during EXEC aborts the ADD
      instrValid = 1'b1; instrOp = 3'b010; instrDst = 3'd3;
      instrSrcA = 3'd1; instrSrcB = 3'd2; instrC = 1'b0;
      tick();
      instrValid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_done", {31'd0, done}, 32'd0);
      chk("t5_ready", {31'd0, instrReady}, 32'd1);
      rd_chk("t5_R3", 3'd3, 16'd0);
      rd_chk("t5_R1", 3'd1, 16'd0);
      tick();
      chk("t5_done_after", {31'd0, done}, 32'd0);

      // 6: IDLE load beats a pending instruction; READ-state load ignored
      instrValid = 1'b1; instrOp = 3'b010; instrDst = 3'd2;
      instrSrcA = 3'd1; instrSrcB = 3'd1; instrC = 1'b0;
      ldEn = 1'b1; ldAddr = 3'd1; ldData = 16'd10;
      #1;
      chk("t6_ready_ld", {31'd0, instrReady}, 32'd0);
      tick();
      ldEn = 1'b0;
      tick();
      instrValid = 1'b0;
      ldEn = 1'b1; ldAddr = 3'd1; ldData = 16'd99;
      tick();
      ldEn = 1'b0;
      repeat (3) tick();
      rd_chk("t6_R2", 3'd2, 16'd20);
      rd_chk("t6_R1", 3'd1, 16'd10);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
